dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder; the target side of the MEM-stage load/store request.
//  - Accepts one request at a time over a valid/ready handshake and performs the byte/half/word access.
//  - Returns load data (sign/zero-extended) or a store acknowledge over a valid/ready response channel.
//  - Sits behind the pipelined core's MEM stage; WAIT models slow memory, so the core's stall logic can be exercised.

---
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Request/response bus between the MEM stage (master) and the
//                data-memory responder (slave).
//                req_*  : request channel, valid/ready handshake
//                rsp_*  : response channel, valid/ready handshake
//                busy   : responder holds an accepted, not yet consumed request
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int N        = 32,
    parameter int MEM_ADDR = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [MEM_ADDR-1:0] req_addr;
    logic [2:0]          req_read;
    logic [1:0]          req_write;
    logic [N-1:0]        req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [N-1:0]        rsp_rdata;
    logic                rsp_err;
    logic                busy;

    modport master (
        output req_valid, req_addr, req_read, req_write, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_read, req_write, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder. Accepts one load/store
//                request at a time, waits WAIT cycles, performs the byte/half/
//                word access exactly once and returns the result.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - dmem_responder_if.slave (request/response channels)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int N        = 32,
    parameter int MEM_ADDR = 8,
    parameter int WAIT     = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dmem_responder_if.slave   bus
);
    localparam int         c_DEPTH = 2 ** (MEM_ADDR - 2);
    localparam logic [3:0] c_WAIT  = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [MEM_ADDR-1:0] r_addr;
    logic [2:0]          r_read;
    logic [1:0]          r_write;
    logic [N-1:0]        r_wdata;
    logic [N-1:0]        r_rdata;
    logic                r_err;
    logic [N-1:0]        r_mem [c_DEPTH];

    logic                w_latch;
    logic                w_enter_resp;
    logic                w_leave_resp;

    // With WAIT=0 the access fires in the accept cycle itself, before the
    // latches are loaded, so the access path looks at the live request then.
    logic [MEM_ADDR-1:0] w_addr;
    logic [2:0]          w_read;
    logic [1:0]          w_write;
    logic [N-1:0]        w_wdata;
    logic [N-1:0]        w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_err;
    logic [N-1:0]        w_ldata;
    logic [N-1:0]        w_sword;

    assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_read  = (r_state == ST_IDLE) ? bus.req_read  : r_read;
    assign w_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
    assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

    assign w_word = r_mem[w_addr[MEM_ADDR-1:2]];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

    assign w_err = ((|w_read) && (|w_write))
                 || (w_read[2:1] == 2'b11)
                 || (((w_read == 3'b010) || (w_read == 3'b101) || (w_write == 2'b10)) && w_addr[0])
                 || (((w_read == 3'b011) || (w_write == 2'b11)) && (w_addr[1:0] != 2'b00));

    always_comb begin
        w_ldata = '0;
        if (!w_err) begin
            case (w_read)
                3'b001:  w_ldata = {{(N-8){w_byte[7]}}, w_byte};
                3'b010:  w_ldata = {{(N-16){w_half[15]}}, w_half};
                3'b011:  w_ldata = w_word;
                3'b100:  w_ldata = {{(N-8){1'b0}}, w_byte};
                3'b101:  w_ldata = {{(N-16){1'b0}}, w_half};
                default: w_ldata = '0;
            endcase
        end
    end

    // Read-modify-write merge: untouched bytes keep their stored value.
    always_comb begin
        w_sword = w_word;
        case (w_write)
            2'b01:   w_sword[{w_addr[1:0], 3'b000} +: 8]  = w_wdata[7:0];
            2'b10:   w_sword[{w_addr[1], 4'b0000} +: 16]  = w_wdata[15:0];
            2'b11:   w_sword = w_wdata;
            default: w_sword = w_word;
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        w_leave_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_latch = 1'b1;
                    if (c_WAIT == 4'd0) begin
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAITING;
                        w_cnt_nxt   = c_WAIT;
                    end
                end
            end
            ST_WAITING: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt  = ST_IDLE;
                    w_leave_resp = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_read  <= 3'b000;
            r_write <= 2'b00;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= bus.req_addr;
                r_read  <= bus.req_read;
                r_write <= bus.req_write;
                r_wdata <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= w_ldata;
                r_err   <= w_err;
            end else if (w_leave_resp) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage is never cleared; the write is gated by rst_n so that a request
    // sitting on the bus during reset cannot slip in a store.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && !w_err && (|w_write)) begin
            r_mem[w_addr[MEM_ADDR-1:2]] <= w_sword;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench: a WAIT=2 responder (dut 0) and a WAIT=0
//                responder (dut 1), a byte-array reference model, and a
//                queue-based scoreboard popped by a response monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    localparam int N  = 32;
    localparam int MA = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if #(.N(N), .MEM_ADDR(MA)) ifa ();
    dmem_responder_if #(.N(N), .MEM_ADDR(MA)) ifb ();

    dmem_responder #(.N(N), .MEM_ADDR(MA), .WAIT(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    dmem_responder #(.N(N), .MEM_ADDR(MA), .WAIT(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  mdl [2][256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          hold_a = 1'b0;
    bit          bp_a = 1'b0;
    bit          b2b = 1'b0;
    int          last_acc_b = -1;
    bit          seen [2];
    logic [31:0] held_d [2];
    logic        held_e [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: little-endian byte array, rules applied directly.
    function automatic void model(input int d, input logic [7:0] a, input logic [2:0] rd,
                                  input logic [1:0] wr, input logic [31:0] wd,
                                  output logic [31:0] res, output logic e);
        int i;
        i   = int'(a);
        res = 32'h0;
        e   = 1'b0;
        if (rd != 3'd0 && wr != 2'd0)                        e = 1'b1;
        else if (rd == 3'd6 || rd == 3'd7)                   e = 1'b1;
        else if ((rd == 3'd2 || rd == 3'd5 || wr == 2'd2) && (i % 2 != 0)) e = 1'b1;
        else if ((rd == 3'd3 || wr == 2'd3) && (i % 4 != 0)) e = 1'b1;
        if (e) return;
        case (rd)
            3'd1: res = {{24{mdl[d][i][7]}}, mdl[d][i]};
            3'd4: res = {24'h0, mdl[d][i]};
            3'd2: res = {{16{mdl[d][i+1][7]}}, mdl[d][i+1], mdl[d][i]};
            3'd5: res = {16'h0, mdl[d][i+1], mdl[d][i]};
            3'd3: res = {mdl[d][i+3], mdl[d][i+2], mdl[d][i+1], mdl[d][i]};
            default: res = 32'h0;
        endcase
        case (wr)
            2'd1: mdl[d][i] = wd[7:0];
            2'd2: begin mdl[d][i] = wd[7:0]; mdl[d][i+1] = wd[15:8]; end
            2'd3: begin
                mdl[d][i] = wd[7:0];   mdl[d][i+1] = wd[15:8];
                mdl[d][i+2] = wd[23:16]; mdl[d][i+3] = wd[31:24];
            end
            default: ;
        endcase
    endfunction

    task automatic drv(input int d, input logic v, input logic [7:0] a, input logic [2:0] r,
                       input logic [1:0] w, input logic [31:0] wd);
        if (d == 0) begin
            ifa.req_valid = v; ifa.req_addr = a; ifa.req_read = r; ifa.req_write = w; ifa.req_wdata = wd;
        end else begin
            ifb.req_valid = v; ifb.req_addr = a; ifb.req_read = r; ifb.req_write = w; ifb.req_wdata = wd;
        end
    endtask

    // mode: 0 = dropped (no model, no expectation), 1 = full, 2 = model only
    task automatic issue(input int d, input logic [7:0] a, input logic [2:0] r,
                         input logic [1:0] w, input logic [31:0] wd, input int mode);
        int          g;
        int          acc;
        logic [31:0] er;
        logic        ee;
        exp_t        x;
        g = 0;
        @(negedge clk);
        while (((d == 0) ? ifa.req_ready : ifb.req_ready) !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            chk("req_ready_timeout", 32'(g), 32'd0);
            return;
        end
        drv(d, 1'b1, a, r, w, wd);
        acc = cyc;
        if (mode != 0) begin
            model(d, a, r, w, wd, er, ee);
            if (mode == 1) begin
                x.rdata = er; x.err = ee; x.acc = acc;
                if (d == 0) qa.push_back(x); else qb.push_back(x);
            end
        end
        if (d == 1 && b2b) begin
            if (last_acc_b >= 0) chk("b2b_gap", 32'(acc - last_acc_b), 32'd2);
            last_acc_b = acc;
        end
        @(posedge clk);
        #1;
        // Garbage on the idle bus must be ignored by a busy responder.
        drv(d, 1'b0, 8'($urandom), 3'($urandom), 2'($urandom), $urandom);
    endtask

    task automatic drain(input int d);
        int g;
        g = 0;
        while (((d == 0) ? qa.size() : qb.size()) > 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) chk("drain_timeout", 32'(g), 32'd0);
        @(negedge clk);
    endtask

    task automatic mon(input int d, input logic v, input logic r, input logic [31:0] rd,
                       input logic e, input int wt);
        exp_t x;
        int   sz;
        if (rst_n !== 1'b1) begin
            seen[d] = 1'b0;
            return;
        end
        if (v !== 1'b1) return;
        sz = (d == 0) ? qa.size() : qb.size();
        if (!seen[d]) begin
            if (sz == 0) begin
                chk("unexpected_rsp", 32'(v), 32'd0);
            end else begin
                x = (d == 0) ? qa[0] : qb[0];
                chk("latency", 32'(cyc - x.acc), 32'(wt + 1));
                chk("rsp_rdata", rd, x.rdata);
                chk("rsp_err", 32'(e), 32'(x.err));
            end
            seen[d]   = 1'b1;
            held_d[d] = rd;
            held_e[d] = e;
        end else begin
            chk("hold_rdata", rd, held_d[d]);
            chk("hold_err", 32'(e), 32'(held_e[d]));
        end
        if (r === 1'b1) begin
            seen[d] = 1'b0;
            if (sz > 0) begin
                if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.rsp_valid, ifa.rsp_ready, ifa.rsp_rdata, ifa.rsp_err, 2);
        mon(1, ifb.rsp_valid, ifb.rsp_ready, ifb.rsp_rdata, ifb.rsp_err, 0);
    end

    always @(posedge clk) begin
        #1;
        ifa.rsp_ready = hold_a ? 1'b0 : (bp_a ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    task automatic chk_reset(input int d);
        if (d == 0) begin
            chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);
            chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
            chk("rst_busy", 32'(ifa.busy), 32'd0);
            chk("rst_rdata", ifa.rsp_rdata, 32'd0);
            chk("rst_err", 32'(ifa.rsp_err), 32'd0);
        end else begin
            chk("rst_b_req_ready", 32'(ifb.req_ready), 32'd1);
            chk("rst_b_rsp_valid", 32'(ifb.rsp_valid), 32'd0);
            chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        end
    endtask

    task automatic rand_req(input int d);
        logic [2:0] r;
        logic [1:0] w;
        r = 3'($urandom);
        w = 2'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) == 0) r = 3'd0; else w = 2'd0;
        end
        issue(d, 8'($urandom), r, w, $urandom, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 1'b0, 8'h0, 3'd0, 2'd0, 32'h0);
        drv(1, 1'b0, 8'h0, 3'd0, 2'd0, 32'h0);
        ifa.rsp_ready = 1'b1;
        ifb.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            issue(0, 8'(i * 4), 3'd0, 2'd3, $urandom, 1);
            issue(1, 8'(i * 4), 3'd0, 2'd3, $urandom, 1);
        end
        drain(0);
        drain(1);

        // Directed sequence on the WAIT=2 responder.
        issue(0, 8'h10, 3'd0, 2'd3, 32'hDEADBEEF, 1);
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h13, 3'd1, 2'd0, 32'h0, 1);
        issue(0, 8'h13, 3'd4, 2'd0, 32'h0, 1);
        issue(0, 8'h12, 3'd2, 2'd0, 32'h0, 1);
        issue(0, 8'h10, 3'd5, 2'd0, 32'h0, 1);
        issue(0, 8'h11, 3'd0, 2'd1, 32'h00000055, 1);
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h12, 3'd0, 2'd2, 32'h00001234, 1);
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h12, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h11, 3'd0, 2'd2, 32'h0000FFFF, 1);
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h10, 3'd1, 2'd3, 32'h0BADF00D, 1);
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        issue(0, 8'h10, 3'd0, 2'd0, 32'hFFFFFFFF, 1);
        issue(0, 8'hFF, 3'd6, 2'd0, 32'h0, 1);
        drain(0);

        // Response backpressure: five stalled cycles, then one handshake.
        hold_a = 1'b1;
        issue(0, 8'h10, 3'd3, 2'd0, 32'h0, 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(ifa.req_ready), 32'd0);
            chk("hold_busy", 32'(ifa.busy), 32'd1);
        end
        hold_a = 1'b0;
        drain(0);
        chk("post_hs_req_ready", 32'(ifa.req_ready), 32'd1);
        chk("post_hs_rsp_valid", 32'(ifa.rsp_valid), 32'd0);

        // Reset while WAITING: the store must not land.
        issue(0, 8'h20, 3'd0, 2'd3, 32'hA5A5A5A5, 0);
        #2;
        chk("mid_busy", 32'(ifa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 8'h20, 3'd3, 2'd0, 32'h0, 1);
        drain(0);

        // Randomised traffic with random response backpressure.
        bp_a = 1'b1;
        for (int i = 0; i < 150; i++) rand_req(0);
        drain(0);
        bp_a = 1'b0;

        // WAIT=0: back-to-back throughput.
        b2b = 1'b1;
        for (int i = 0; i < 30; i++) rand_req(1);
        drain(1);
        b2b = 1'b0;

        // WAIT=0, reset during RESP: the store has already completed.
        issue(1, 8'h24, 3'd0, 2'd3, 32'h5A5A5A5A, 2);
        #2;
        chk("b_mid_valid", 32'(ifb.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset(1);
        chk("rst_b_rdata", ifb.rsp_rdata, 32'd0);
        qb.delete();
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 8'h24, 3'd3, 2'd0, 32'h0, 1);
        issue(1, 8'h26, 3'd2, 2'd0, 32'h0, 1);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
